// File: rtl/imem_responder.sv
// Instruction memory responder: grants fetches, drives the SRAM macro,
// keeps a one-word bypass buffer and flags bad addresses.
module imem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           mem_rd_i,
  input  logic [31:0]                    mem_addr_i,
  output logic                           mem_gnt_o,
  output logic                           mem_rvalid_o,
  output logic [31:0]                    mem_rdata_o,
  output logic                           mem_err_o,
  input  logic                           flush_i,
  output logic                           sram_csb_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr_o,
  input  logic [31:0]                    sram_rdata_i
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   miss_idx_q;
  logic            buf_valid_q;
  logic [AW-1:0]   buf_tag_q;
  logic [31:0]     buf_data_q;
  logic            flush_pend_q;

  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            addr_err;
  logic            hit;
  logic            miss_go;
  logic            done;

  assign off      = mem_addr_i - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign addr_err = (off[1:0] != 2'b00)
                  | (off[31:AW+2] != '0);
  assign hit      = ~addr_err & buf_valid_q
                  & (buf_tag_q == idx) & ~flush_i;
  assign miss_go  = mem_gnt_o & ~addr_err & ~hit;
  assign done     = (state_q == S_WAIT)
                  & (cnt_q == 4'd0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state: a miss parks in WAIT until the SRAM data is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (miss_go) state_d = S_WAIT;
      S_WAIT: if (cnt_q == 4'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant and SRAM strobe; only a granted miss touches the macro.
  always_comb begin
    mem_gnt_o   = mem_rd_i & (state_q == S_IDLE);
    sram_csb_o  = ~miss_go;
    sram_addr_o = idx;
  end

  // Wait-state counter and captured miss index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= 4'd0;
      miss_idx_q <= '0;
    end else if (miss_go) begin
      cnt_q      <= 4'(WAIT_CYCLES);
      miss_idx_q <= idx;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Response register: one pulse per grant, data held between pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rvalid_o <= 1'b0;
      mem_err_o    <= 1'b0;
      mem_rdata_o  <= 32'h0;
    end else begin
      mem_rvalid_o <= 1'b0;
      mem_err_o    <= 1'b0;
      if (done) begin
        mem_rvalid_o <= 1'b1;
        mem_rdata_o  <= sram_rdata_i;
      end else if (mem_gnt_o) begin
        unique case (1'b1)
          addr_err: begin
            mem_rvalid_o <= 1'b1;
            mem_err_o    <= 1'b1;
            mem_rdata_o  <= 32'h0;
          end
          hit: begin
            mem_rvalid_o <= 1'b1;
            mem_rdata_o  <= buf_data_q;
          end
          default: ;
        endcase
      end
    end
  end

  // Last-word buffer; a flush seen during WAIT keeps the fill invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= 32'h0;
      flush_pend_q <= 1'b0;
    end else if (done) begin
      buf_valid_q  <= ~(flush_pend_q | flush_i);
      buf_tag_q    <= miss_idx_q;
      buf_data_q   <= sram_rdata_i;
      flush_pend_q <= 1'b0;
    end else if (flush_i) begin
      buf_valid_q <= 1'b0;
      if (state_q == S_WAIT) flush_pend_q <= 1'b1;
    end
  end

endmodule
